// File: rtl/dmem_access_ctrl_if.sv
// Request/response channel and data-RAM port between the M stage and the data-memory controller.
// slave = controller side; master = M stage plus RAM side.
interface dmem_access_ctrl_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [63:0] resp_rdata_o;
    logic        resp_err_o;
    logic        m_r_en_o;
    logic        m_w_en_o;
    logic [63:0] m_addr_o;
    logic [63:0] m_wdata_o;
    logic [63:0] m_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i, m_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output m_r_en_o, m_w_en_o, m_addr_o, m_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i, m_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  m_r_en_o, m_w_en_o, m_addr_o, m_wdata_o
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Y86 data-memory initiator: bounds-checks one request at a time, with an alignment check under DMEM_ALIGN_CHECK_EN.
// Latency is 1 cycle for errors, RD_WAIT+1 for loads, 2 for stores.
// One request in flight; req_ready_o is low and stall_o is high until the response handshakes.
module dmem_access_ctrl #(
    parameter int unsigned MEM_BYTES  = 1024,
    parameter int unsigned WORD_BYTES = 8,
    parameter int unsigned RD_WAIT    = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    dmem_access_ctrl_if.slave   bus,
    output logic                stall_o
);

    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - WORD_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic        m_r_en_q, m_r_en_d;
    logic        m_w_en_q, m_w_en_d;
    logic [63:0] m_addr_q, m_addr_d;
    logic [63:0] m_wdata_q, m_wdata_d;

    logic req_ready;
    logic accept;
    logic addr_err;

    assign req_ready = (state_q == S_IDLE) & ~rst_i;
    assign accept    = bus.req_valid_i & req_ready;

    // Plain compare against the last legal word start: no addition, so no wrap near 2^64.
`ifdef DMEM_ALIGN_CHECK_EN
    assign addr_err = (bus.req_addr_i > MAX_ADDR) | (bus.req_addr_i[2:0] != 3'b000);
`else
    assign addr_err = (bus.req_addr_i > MAX_ADDR);
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        m_r_en_d     = m_r_en_q;
        m_w_en_d     = m_w_en_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (addr_err) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 64'd0;
                    end else if (bus.req_we_i) begin
                        state_d   = S_WR;
                        m_addr_d  = bus.req_addr_i;
                        m_wdata_d = bus.req_wdata_i;
                        m_w_en_d  = 1'b1;
                    end else begin
                        state_d  = S_RD;
                        m_addr_d = bus.req_addr_i;
                        m_r_en_d = 1'b1;
                        cnt_d    = 4'(RD_WAIT - 1);
                    end
                end
            end
            S_RD: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d      = S_RESP;
                    m_r_en_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = bus.m_rdata_i;
                end
            end
            S_WR: begin
                state_d      = S_RESP;
                m_w_en_d     = 1'b0;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = 64'd0;
            end
            S_RESP: begin
                if (bus.resp_ready_i) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 64'd0;
            m_r_en_q     <= 1'b0;
            m_w_en_q     <= 1'b0;
            m_addr_q     <= 64'd0;
            m_wdata_q    <= 64'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            m_r_en_q     <= m_r_en_d;
            m_w_en_q     <= m_w_en_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
        end
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_err_o   = resp_err_q;
    assign bus.resp_rdata_o = resp_rdata_q;
    assign bus.m_r_en_o     = m_r_en_q;
    assign bus.m_w_en_o     = m_w_en_q;
    assign bus.m_addr_o     = m_addr_q;
    assign bus.m_wdata_o    = m_wdata_q;
    assign stall_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench: dut_a runs RD_WAIT=1, dut_b runs RD_WAIT=3, both on one byte-array RAM model.
module tb_dmem_access_ctrl;

    bit clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vld_a, vld_b, req_we, resp_ready;
    logic [63:0] req_addr, req_wdata;
    bit          sel;

    dmem_access_ctrl_if ifa ();
    dmem_access_ctrl_if ifb ();
    logic stall_a, stall_b;

    dmem_access_ctrl #(.MEM_BYTES(1024), .WORD_BYTES(8), .RD_WAIT(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(ifa), .stall_o(stall_a));
    dmem_access_ctrl #(.MEM_BYTES(1024), .WORD_BYTES(8), .RD_WAIT(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(ifb), .stall_o(stall_b));

    assign ifa.req_valid_i  = vld_a;
    assign ifb.req_valid_i  = vld_b;
    assign ifa.req_we_i     = req_we;
    assign ifb.req_we_i     = req_we;
    assign ifa.req_addr_i   = req_addr;
    assign ifb.req_addr_i   = req_addr;
    assign ifa.req_wdata_i  = req_wdata;
    assign ifb.req_wdata_i  = req_wdata;
    assign ifa.resp_ready_i = resp_ready;
    assign ifb.resp_ready_i = resp_ready;

    // RAM model: byte array, little-endian, combinational read, write at the clock edge.
    logic [7:0] mem [0:1023];
    bit         mem_init_done = 1'b0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i);
            mem_init_done <= 1'b1;
        end else begin
            if (ifa.m_w_en_o)
                for (int k = 0; k < 8; k++) mem[10'(ifa.m_addr_o[9:0] + 10'(k))] <= ifa.m_wdata_o[8*k +: 8];
            if (ifb.m_w_en_o)
                for (int k = 0; k < 8; k++) mem[10'(ifb.m_addr_o[9:0] + 10'(k))] <= ifb.m_wdata_o[8*k +: 8];
        end
    end

    always_comb begin
        ifa.m_rdata_i = 64'd0;
        ifb.m_rdata_i = 64'd0;
        for (int k = 0; k < 8; k++) begin
            ifa.m_rdata_i[8*k +: 8] = mem[10'(ifa.m_addr_o[9:0] + 10'(k))];
            ifb.m_rdata_i[8*k +: 8] = mem[10'(ifb.m_addr_o[9:0] + 10'(k))];
        end
    end

    logic        o_req_ready, o_resp_valid, o_err, o_r_en, o_w_en, o_stall;
    logic [63:0] o_rdata;
    always_comb begin
        o_req_ready  = sel ? ifb.req_ready_o  : ifa.req_ready_o;
        o_resp_valid = sel ? ifb.resp_valid_o : ifa.resp_valid_o;
        o_err        = sel ? ifb.resp_err_o   : ifa.resp_err_o;
        o_rdata      = sel ? ifb.resp_rdata_o : ifa.resp_rdata_o;
        o_r_en       = sel ? ifb.m_r_en_o     : ifa.m_r_en_o;
        o_w_en       = sel ? ifb.m_w_en_o     : ifa.m_w_en_o;
        o_stall      = sel ? stall_b          : stall_a;
    end

    int n_vec = 0;
    int n_err = 0;

    int          lat, ren, wen;
    logic [63:0] rd;
    logic        er;
    bit          st, ia;

    // Issues one request and collects what happened; lat = -1 on a timeout.
    task automatic run_req(input bit s, input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                           input int hold, output int lat_o, output logic [63:0] rdata_o, output logic err_o,
                           output int ren_o, output int wen_o, output bit stable_o, output bit idle_o);
        bit acc;
        acc = 1'b0;
        sel = s; req_we = we; req_addr = addr; req_wdata = wdata;
        if (s) vld_b = 1'b1; else vld_a = 1'b1;
        lat_o = -1; rdata_o = '1; err_o = 1'bx; ren_o = 0; wen_o = 0; stable_o = 1'b1; idle_o = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (o_req_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        vld_a = 1'b0; vld_b = 1'b0;
        if (!acc) return;
        lat_o = 1;
        while (!o_resp_valid && lat_o < 40) begin
            ren_o += int'(o_r_en); wen_o += int'(o_w_en);
            @(posedge clk); #1;
            lat_o++;
        end
        ren_o += int'(o_r_en); wen_o += int'(o_w_en);
        if (!o_resp_valid) begin lat_o = -1; return; end
        rdata_o = o_rdata; err_o = o_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!o_resp_valid || o_rdata !== rdata_o || o_err !== err_o || o_req_ready || !o_stall || o_r_en || o_w_en)
                stable_o = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        idle_o = !o_resp_valid && !o_stall && o_req_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1; vld_a = 1'b1; vld_b = 1'b0; req_we = 1'b0; req_addr = 64'd0; req_wdata = 64'd0; resp_ready = 1'b0;
        @(posedge clk); #1; @(posedge clk); #1;
        n_vec++; if (ifa.req_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ifa.req_ready_o); end
        n_vec++; if ({ifa.resp_valid_o, ifa.resp_err_o, ifa.m_r_en_o, ifa.m_w_en_o, stall_a} !== 5'b0) begin n_err++;
            $display("FAIL reset_ctl_a: got %b want 00000", {ifa.resp_valid_o, ifa.resp_err_o, ifa.m_r_en_o, ifa.m_w_en_o, stall_a}); end
        n_vec++; if ({ifa.resp_rdata_o, ifa.m_addr_o, ifa.m_wdata_o} !== 192'd0) begin n_err++;
            $display("FAIL reset_data_a: got %h %h %h want 0", ifa.resp_rdata_o, ifa.m_addr_o, ifa.m_wdata_o); end
        n_vec++; if ({ifb.resp_valid_o, ifb.m_r_en_o, ifb.m_w_en_o, stall_b} !== 4'b0) begin n_err++;
            $display("FAIL reset_ctl_b: got %b want 0000", {ifb.resp_valid_o, ifb.m_r_en_o, ifb.m_w_en_o, stall_b}); end
        vld_a = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        n_vec++; if ({stall_a, ifa.m_r_en_o, ifa.req_ready_o} !== 3'b001) begin n_err++;
            $display("FAIL reset_ignored_req: got %b want 001", {stall_a, ifa.m_r_en_o, ifa.req_ready_o}); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        sel = 1'b1; req_we = 1'b0; req_addr = 64'd0; vld_b = 1'b1;
        @(posedge clk); #1;
        vld_b = 1'b0;
        @(posedge clk); #1;
        n_vec++; if ({stall_b, ifb.m_r_en_o} !== 2'b11) begin n_err++; $display("FAIL mid_in_rd: got %b want 11", {stall_b, ifb.m_r_en_o}); end
        rst = 1'b1;
        n_vec++; if (ifb.req_ready_o !== 1'b0) begin n_err++; $display("FAIL mid_ready_in_rst: got %b want 0", ifb.req_ready_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if ({stall_b, ifb.m_r_en_o, ifb.resp_valid_o} !== 3'b000) begin n_err++;
            $display("FAIL mid_idle: got %b want 000", {stall_b, ifb.m_r_en_o, ifb.resp_valid_o}); end
        for (int i = 0; i < 6; i++) begin
            if (ifb.resp_valid_o) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_no_resp: got %b want 0", seen); end
        run_req(1'b1, 1'b0, 64'd0, 64'd0, 0, lat, rd, er, ren, wen, st, ia);
        n_vec++; if (lat !== 4 || rd !== 64'h0706050403020100 || er !== 1'b0) begin n_err++;
            $display("FAIL mid_after_load: got lat %0d rdata %h err %b want 4 0706050403020100 0", lat, rd, er); end
    endtask

    task automatic test_rd_wait3_align();
        run_req(1'b1, 1'b0, 64'd0, 64'd0, 0, lat, rd, er, ren, wen, st, ia);
        n_vec++; if (ren !== 3 || lat !== 4) begin n_err++; $display("FAIL rw3_timing: got ren %0d lat %0d want 3 4", ren, lat); end
        n_vec++; if (rd !== 64'h0706050403020100 || ia !== 1'b1) begin n_err++; $display("FAIL rw3_data: got %h idle %b want 0706050403020100 1", rd, ia); end
        run_req(1'b1, 1'b0, 64'd4, 64'd0, 0, lat, rd, er, ren, wen, st, ia);
`ifdef DMEM_ALIGN_CHECK_EN
        n_vec++; if (er !== 1'b1 || rd !== 64'd0 || lat !== 1 || ren !== 0) begin n_err++;
            $display("FAIL align_addr4: got err %b rdata %h lat %0d ren %0d want 1 0 1 0", er, rd, lat, ren); end
`else
        n_vec++; if (er !== 1'b0 || rd !== 64'h0B0A090807060504 || lat !== 4) begin n_err++;
            $display("FAIL align_addr4: got err %b rdata %h lat %0d want 0 0b0a090807060504 4", er, rd, lat); end
`endif
    endtask

    task automatic test_load_basic();
        run_req(1'b0, 1'b0, 64'd0, 64'd0, 0, lat, rd, er, ren, wen, st, ia);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL load_lat: got %0d want 2", lat); end
        n_vec++; if (rd !== 64'h0706050403020100 || er !== 1'b0) begin n_err++;
            $display("FAIL load_data: got %h err %b want 0706050403020100 0", rd, er); end
        n_vec++; if (ren !== 1 || wen !== 0 || ia !== 1'b1) begin n_err++;
            $display("FAIL load_en: got ren %0d wen %0d idle %b want 1 0 1", ren, wen, ia); end
    endtask

    task automatic test_store_load();
        run_req(1'b0, 1'b1, 64'd8, 64'h1122334455667788, 0, lat, rd, er, ren, wen, st, ia);
        n_vec++; if (wen !== 1 || ren !== 0 || lat !== 2) begin n_err++;
            $display("FAIL store_en: got wen %0d ren %0d lat %0d want 1 0 2", wen, ren, lat); end
        n_vec++; if (rd !== 64'd0 || er !== 1'b0) begin n_err++; $display("FAIL store_resp: got %h err %b want 0 0", rd, er); end
        run_req(1'b0, 1'b0, 64'd8, 64'd0, 0, lat, rd, er, ren, wen, st, ia);
        n_vec++; if (rd !== 64'h1122334455667788 || er !== 1'b0) begin n_err++;
            $display("FAIL store_readback: got %h err %b want 1122334455667788 0", rd, er); end
    endtask

    task automatic test_bounds();
        run_req(1'b0, 1'b0, 64'd1016, 64'd0, 0, lat, rd, er, ren, wen, st, ia);
        n_vec++; if (rd !== 64'hFFFEFDFCFBFAF9F8 || er !== 1'b0 || lat !== 2) begin n_err++;
            $display("FAIL bound_1016: got %h err %b lat %0d want fffefdfcfbfaf9f8 0 2", rd, er, lat); end
        run_req(1'b0, 1'b0, 64'd1017, 64'd0, 0, lat, rd, er, ren, wen, st, ia);
        n_vec++; if (er !== 1'b1 || rd !== 64'd0 || lat !== 1 || ren !== 0 || wen !== 0) begin n_err++;
            $display("FAIL bound_1017: got err %b rdata %h lat %0d ren %0d wen %0d want 1 0 1 0 0", er, rd, lat, ren, wen); end
        run_req(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, lat, rd, er, ren, wen, st, ia);
        n_vec++; if (er !== 1'b1 || rd !== 64'd0 || lat !== 1 || ren !== 0 || wen !== 0) begin n_err++;
            $display("FAIL bound_max: got err %b rdata %h lat %0d ren %0d wen %0d want 1 0 1 0 0", er, rd, lat, ren, wen); end
        run_req(1'b0, 1'b1, 64'd1024, 64'hDEAD_BEEF_0000_0001, 0, lat, rd, er, ren, wen, st, ia);
        n_vec++; if (er !== 1'b1 || wen !== 0 || lat !== 1 || ia !== 1'b1) begin n_err++;
            $display("FAIL bound_store: got err %b wen %0d lat %0d idle %b want 1 0 1 1", er, wen, lat, ia); end
    endtask

    task automatic test_backpressure();
        run_req(1'b0, 1'b0, 64'd16, 64'd0, 3, lat, rd, er, ren, wen, st, ia);
        n_vec++; if (rd !== 64'h1716151413121110 || er !== 1'b0) begin n_err++;
            $display("FAIL bp_data: got %h err %b want 1716151413121110 0", rd, er); end
        n_vec++; if (st !== 1'b1) begin n_err++; $display("FAIL bp_stable: got %b want 1", st); end
        n_vec++; if (ia !== 1'b1) begin n_err++; $display("FAIL bp_idle_after: got %b want 1", ia); end
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_reset_mid();
        test_rd_wait3_align();
        test_load_basic();
        test_store_load();
        test_bounds();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
